// File: rtl/dac_buf.sv
// dac_buf: 2048-byte dual-port buffer. Port A writes single bytes; port B
// reads little-endian 32-bit words through a registered output.
// Optional macro DAC_BUF_OUTREG_EN adds a second output register, which
// raises the read latency from 1 to 2.
// Memory contents power up as zero. Reset clears only the output
// pipeline and never touches the stored bytes.
module dac_buf (
   input  logic        clkin,
   input  logic        reset,
   input  logic        wea,
   input  logic [10:0] addra,
   input  logic [7:0]  dina,
   input  logic [8:0]  addrb,
   output logic [31:0] doutb
);

   // Split the byte address into a word index and a byte lane within that word.
   logic [8:0]  word_a;
   logic [1:0]  lane_a;
   logic [31:0] rd_word;

   assign word_a = addra[10:2];
   assign lane_a = addra[1:0];

   // One 512x8 memory per byte lane. A write therefore touches only the
   // addressed lane, and the other three bytes of the word stay as they are.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = gi;

         logic [7:0] mem [0:511] = '{default: 8'h00};
         logic [7:0] lane_reg;

         // Byte write. It is still performed while reset is high.
         always_ff @(posedge clkin) begin
            if (wea && (lane_a == LANE)) begin
               mem[word_a] <= dina;
            end
         end

         // Registered read. A read and a write to the same word on one edge
         // return the old contents (read-first behaviour).
         always_ff @(posedge clkin) begin
            if (reset) begin
               lane_reg <= 8'h00;
            end else begin
               lane_reg <= mem[addrb];
            end
         end

         assign rd_word[8*gi +: 8] = lane_reg;
      end
   endgenerate

`ifdef DAC_BUF_OUTREG_EN
   logic [31:0] out_reg;

   // Second output stage. It clears together with the read stage.
   always_ff @(posedge clkin) begin
      if (reset) begin
         out_reg <= 32'h0000_0000;
      end else begin
         out_reg <= rd_word;
      end
   end

   assign doutb = out_reg;
`else
   assign doutb = rd_word;
`endif

endmodule

// File: tb/tb_dac_buf.sv
// tb_dac_buf: directed and random checks of dac_buf against a byte-array
// model. The model packs bytes little-endian and delays reads by the
// configured latency.
module tb_dac_buf;

`ifdef DAC_BUF_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clkin = 1'b0;
   logic        reset = 1'b1;
   logic        wea   = 1'b0;
   logic [10:0] addra = '0;
   logic [7:0]  dina  = '0;
   logic [8:0]  addrb = '0;
   logic [31:0] doutb;

   int errors = 0;
   int checks = 0;

   logic [7:0]  mem_m [2048];
   logic [31:0] pipe0 = '0;
   logic [31:0] pipe1 = '0;

   dac_buf dut (
      .clkin (clkin),
      .reset (reset),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .addrb (addrb),
      .doutb (doutb)
   );

   always #5 clkin = ~clkin;

   function automatic logic [31:0] model_word(input int w);
      return {mem_m[4*w+3], mem_m[4*w+2], mem_m[4*w+1], mem_m[4*w]};
   endfunction

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: doutb=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge. Advance the model (read old contents first, then write),
   // then check doutb shortly after the edge.
   task automatic cyc(input string tag);
      @(posedge clkin);
      if (reset) begin
         pipe0 = '0;
         pipe1 = '0;
      end else begin
         pipe1 = pipe0;
         pipe0 = model_word(int'(addrb));
      end
      if (wea) mem_m[addra] = dina;
      #1;
      chk(doutb, (LAT == 1) ? pipe0 : pipe1, tag);
   endtask

   task automatic wr(input logic [10:0] a, input logic [7:0] d);
      wea = 1'b1; addra = a; dina = d;
      cyc("write");
      wea = 1'b0;
   endtask

   task automatic rd(input logic [8:0] w, input logic [31:0] exp, input string tag);
      wea = 1'b0; addrb = w;
      repeat (LAT) cyc("read");
      chk(doutb, exp, tag);
   endtask

   initial begin
      foreach (mem_m[i]) mem_m[i] = 8'h00;

      // Reset: the output pipeline clears.
      #1;
      reset = 1'b1;
      cyc("reset0");
      cyc("reset1");
      chk(doutb, 32'h0, "reset_state");
      reset = 1'b0;

      // Power-up contents are zero.
      rd(9'd100, 32'h0, "powerup_zero");

      // Fill word 0 with four bytes and read it back as one word.
      wr(11'd0, 8'h11); wr(11'd1, 8'h22); wr(11'd2, 8'h33); wr(11'd3, 8'h44);
      rd(9'd0, 32'h44332211, "word0_le");

      // Write the top byte and read the top word.
      wr(11'd2047, 8'hAB);
      rd(9'd511, 32'hAB000000, "top_byte");

      // Same-word collision: the read returns the old word.
      wr(11'd20, 8'h11); wr(11'd21, 8'h22); wr(11'd22, 8'h33); wr(11'd23, 8'h44);
      rd(9'd5, 32'h44332211, "word5_init");
      wea = 1'b1; addra = 11'd21; dina = 8'hFF; addrb = 9'd5;
      cyc("coll_edge");
      wea = 1'b0;
      repeat (LAT - 1) cyc("coll_wait");
      chk(doutb, 32'h44332211, "coll_old");
      cyc("coll_next");
      chk(doutb, 32'h4433FF11, "coll_new");

      // Reset clears the output but keeps memory.
      rd(9'd0, 32'h44332211, "pre_reset");
      reset = 1'b1;
      cyc("rst_edge");
      chk(doutb, 32'h0, "rst_clear");
      reset = 1'b0;
      rd(9'd0, 32'h44332211, "post_reset");

      // Reset mid-read discards the in-flight word 5.
      addrb = 9'd5;
      cyc("inflight");
      reset = 1'b1;
      cyc("mid_rst");
      chk(doutb, 32'h0, "mid_rst_clear");
      reset = 1'b0; addrb = 9'd0;
      cyc("post_mid");
      chk(doutb, (LAT == 1) ? 32'h44332211 : 32'h0, "no_stale");

      // A write issued during reset is still performed.
      reset = 1'b1;
      wr(11'd8, 8'h5A);
      reset = 1'b0;
      rd(9'd2, 32'h0000005A, "write_in_reset");

      // Independent ports: write one word while reading a different word.
      wea = 1'b1; addra = 11'd40; dina = 8'h77; addrb = 9'd5;
      cyc("indep_edge");
      wea = 1'b0;
      rd(9'd10, 32'h00000077, "indep_write");

      // With wea low, toggling the address and data leaves memory unchanged.
      for (int i = 0; i < 50; i++) begin
         wea = 1'b0; addra = 11'($urandom); dina = 8'($urandom);
         cyc("wea_low");
      end
      rd(9'd0,   32'h44332211, "hold_w0");
      rd(9'd5,   32'h4433FF11, "hold_w5");
      rd(9'd511, 32'hAB000000, "hold_w511");

      // Random traffic with occasional resets and forced same-word reads.
      for (int i = 0; i < 10000; i++) begin
         wea   = 1'($urandom);
         addra = 11'($urandom);
         dina  = 8'($urandom);
         addrb = ($urandom_range(0, 3) == 0) ? addra[10:2] : 9'($urandom);
         reset = ($urandom_range(0, 63) == 0);
         cyc("random");
      end
      reset = 1'b0;
      wea   = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dac_buf.md
DAC_BUF -- requirements
Module: dac_buf

Interface
REQ-001 Reset reset, synchronous, active-high; clock clkin.
REQ-002 clkin  input  1  single clock for both ports; all state changes on rising edge.
REQ-003 reset  input  1  synchronous active-high reset of output pipeline only.
REQ-004 wea  input  1  port A byte write enable, active-high.
REQ-005 addra  input  11  port A byte address, 0..2047.
REQ-006 dina  input  8  port A write data byte.
REQ-007 addrb  input  9  port B 32-bit word address, 0..511.
REQ-008 doutb  output  32  port B registered read data.

Function
REQ-009 Storage SHALL be 2048 bytes, also viewed as 512 words of 32 bits; write-only port A, read-only port B.
REQ-010 Mapping SHALL be little-endian: byte address 4*W+k occupies doutb bits [8k+7:8k] of word W, k=0..3.
REQ-011 With wea=1 at a rising edge, dina SHALL be stored at addra; with wea=0, memory SHALL be unchanged.
REQ-012 Only the addressed byte SHALL change on a write; the other three bytes of that word SHALL be preserved.
REQ-013 Port B SHALL sample addrb each rising edge; doutb SHALL present the word one edge later (latency 1) when the macro in REQ-024 is undefined.
REQ-014 doutb SHALL hold its value between edges and change only on a rising edge.
REQ-015 Same-word collision: if port A writes any byte of word W on the edge port B samples W, doutb SHALL show the pre-write (old) contents; the new byte SHALL be visible from the next read.
REQ-016 Address ranges SHALL be full width; no out-of-range case exists and no wrap logic is needed.
REQ-017 Ports SHALL operate independently; a write and a read of different words on the same edge SHALL both complete correctly.
REQ-018 Memory content after power-up SHALL be all zero.

Reset
REQ-019 While reset=1 at a rising edge, doutb (and any pipeline register) SHALL become 32'h0000_0000.
REQ-020 Reset SHALL NOT clear or modify memory contents.
REQ-021 Writes with wea=1 during reset SHALL still be performed.
REQ-022 After reset is deasserted, the first valid doutb SHALL appear after the normal latency following the first non-reset edge.
REQ-023 Reset asserted mid-read SHALL discard the in-flight read; no stale data SHALL appear after reset.

Configuration
REQ-024 Macro DAC_BUF_OUTREG_EN: when defined, an extra output register SHALL follow the read register, giving latency 2; both stages SHALL clear on reset. When undefined, latency SHALL be 1 with a single register.

Verification
REQ-025 Write bytes 0x11,0x22,0x33,0x44 to addra 0..3, then read addrb=0 -> doutb=32'h44332211 one edge later (two with macro).
REQ-026 Write 0xAB to addra=2047, read addrb=511 -> doutb[31:24]=0xAB, doutb[23:0] unchanged at 0.
REQ-027 Word 5 holds 0x44332211; on one edge write 0xFF to addra=21 and read addrb=5 -> doutb=32'h44332211; next read -> 32'h4433FF11.
REQ-028 Assert reset with doutb=32'h44332211 -> doutb=0 next edge; deassert and read addrb=0 -> 32'h44332211 (memory kept).
REQ-029 Random writes and reads over 10000 cycles against a byte-array model, little-endian packing -> zero mismatches at correct latency.
REQ-030 Hold wea=0 with toggling dina/addra, then read back -> contents unchanged.
